// File: rtl/tjmono2_cmd_rx.sv
// Serial command receiver: finds 16-bit frame alignment on the sync word, locks to
// the sync cadence and decodes each data frame through the 8b->5b symbol table.
module tjmono2_cmd_rx #(
    parameter logic [15:0] SYNC_WORD     = 16'h817E,
    parameter logic [15:0] NOOP_WORD     = 16'h6969,
    parameter int          SYNC_LOCK     = 4,
    parameter int          NO_SYNC_LIMIT = 64
) (
    input  logic        CMD_CLK,
    input  logic        RESETB,
    input  logic        ENABLE,
    input  logic        CMD_SERIAL,
    output logic        LOCKED,
    output logic        FRAME_VALID,
    output logic [15:0] FRAME_RAW,
    output logic [9:0]  FRAME_DATA,
    output logic        FRAME_DATA_OK,
    output logic [15:0] SYNC_CNT,
    output logic [15:0] FRAME_CNT,
    output logic        LOCK_LOST
);

    typedef enum logic [1:0] {ST_SEARCH, ST_ALIGN, ST_LOCKED} state_t;

    typedef struct packed {
        logic [15:0] raw;
        logic [9:0]  data;
        logic        ok;
    } frame_t;

    localparam logic [3:0] LOCK_N  = 4'(SYNC_LOCK);
    localparam logic [7:0] NOSYNC_N = 8'(NO_SYNC_LIMIT);

    // {valid, symbol index}; anything outside the table yields 0 and valid=0
    function automatic logic [5:0] sym_dec(input logic [7:0] b);
        logic [5:0] r;
        r = 6'd0;
        case (b)
            8'h6A: r = {1'b1, 5'd0};
            8'h6C: r = {1'b1, 5'd1};
            8'h71: r = {1'b1, 5'd2};
            8'h72: r = {1'b1, 5'd3};
            8'h74: r = {1'b1, 5'd4};
            8'h8B: r = {1'b1, 5'd5};
            8'h8D: r = {1'b1, 5'd6};
            8'h8E: r = {1'b1, 5'd7};
            8'h93: r = {1'b1, 5'd8};
            8'h95: r = {1'b1, 5'd9};
            8'h96: r = {1'b1, 5'd10};
            8'h99: r = {1'b1, 5'd11};
            8'h9A: r = {1'b1, 5'd12};
            8'h9C: r = {1'b1, 5'd13};
            8'hA3: r = {1'b1, 5'd14};
            8'hA5: r = {1'b1, 5'd15};
            8'hA6: r = {1'b1, 5'd16};
            8'hA9: r = {1'b1, 5'd17};
            8'hAA: r = {1'b1, 5'd18};
            8'hAC: r = {1'b1, 5'd19};
            8'hB1: r = {1'b1, 5'd20};
            8'hB2: r = {1'b1, 5'd21};
            8'hB4: r = {1'b1, 5'd22};
            8'hC3: r = {1'b1, 5'd23};
            8'hC5: r = {1'b1, 5'd24};
            8'hC6: r = {1'b1, 5'd25};
            8'hC9: r = {1'b1, 5'd26};
            8'hCA: r = {1'b1, 5'd27};
            8'hCC: r = {1'b1, 5'd28};
            8'hD1: r = {1'b1, 5'd29};
            8'hD2: r = {1'b1, 5'd30};
            8'hD4: r = {1'b1, 5'd31};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_nxt;
    logic [3:0]  bc_q, bc_d;
    logic [3:0]  run_q, run_d;
    logic [7:0]  nosync_q, nosync_d;
    logic        emit, sync_inc, lost_d;
    logic        is_sync, is_noop, boundary;
    logic [5:0]  dec_hi, dec_lo;
    frame_t      frame_d;

    assign sr_nxt   = {sr_q[14:0], CMD_SERIAL};
    assign is_sync  = (sr_nxt == SYNC_WORD);
    assign is_noop  = (sr_nxt == NOOP_WORD);
    // bc==15 means this edge shifts in the 16th bit after the previous frame
    assign boundary = (bc_q == 4'd15);
    assign LOCKED   = (state_q == ST_LOCKED);

    assign dec_hi = sym_dec(sr_nxt[15:8]);
    assign dec_lo = sym_dec(sr_nxt[7:0]);
    assign frame_d = '{raw: sr_nxt, data: {dec_hi[4:0], dec_lo[4:0]}, ok: dec_hi[5] & dec_lo[5]};

    always_comb begin
        state_d  = state_q;
        bc_d     = bc_q + 4'd1;
        run_d    = run_q;
        nosync_d = nosync_q;
        emit     = 1'b0;
        sync_inc = 1'b0;
        lost_d   = 1'b0;
        if (!ENABLE) begin
            state_d  = ST_SEARCH;
            run_d    = 4'd0;
            nosync_d = 8'd0;
            lost_d   = (state_q == ST_LOCKED);
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_sync) begin
                        bc_d     = 4'd0;
                        run_d    = 4'd1;
                        nosync_d = 8'd0;
                        state_d  = (LOCK_N == 4'd1) ? ST_LOCKED : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (boundary) begin
                        if (is_sync) begin
                            run_d = run_q + 4'd1;
                            if (run_q + 4'd1 == LOCK_N) begin
                                state_d  = ST_LOCKED;
                                nosync_d = 8'd0;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            run_d   = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (is_sync) begin
                            sync_inc = 1'b1;
                            nosync_d = 8'd0;
                        end else begin
                            // a data frame on the lock-dropping boundary is still delivered
                            emit     = !is_noop;
                            nosync_d = nosync_q + 8'd1;
                            if (nosync_q + 8'd1 == NOSYNC_N) begin
                                state_d = ST_SEARCH;
                                run_d   = 4'd0;
                                lost_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge CMD_CLK) begin
        if (!RESETB) begin
            state_q       <= ST_SEARCH;
            sr_q          <= '0;
            bc_q          <= '0;
            run_q         <= '0;
            nosync_q      <= '0;
            FRAME_VALID   <= 1'b0;
            LOCK_LOST     <= 1'b0;
            FRAME_RAW     <= '0;
            FRAME_DATA    <= '0;
            FRAME_DATA_OK <= 1'b0;
            SYNC_CNT      <= '0;
            FRAME_CNT     <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_nxt;
            bc_q        <= bc_d;
            run_q       <= run_d;
            nosync_q    <= nosync_d;
            FRAME_VALID <= emit;
            LOCK_LOST   <= lost_d;
            if (emit) begin
                FRAME_RAW     <= frame_d.raw;
                FRAME_DATA    <= frame_d.data;
                FRAME_DATA_OK <= frame_d.ok;
                FRAME_CNT     <= FRAME_CNT + 16'd1;
            end
            if (sync_inc && SYNC_CNT != 16'hFFFF)
                SYNC_CNT <= SYNC_CNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_tjmono2_cmd_rx.sv
// Bench for tjmono2_cmd_rx: directed and random bit streams against a frame-level
// reference model that tracks alignment by bit position relative to the last sync.
`timescale 1ns/1ps
module tb_tjmono2_cmd_rx;
    localparam logic [15:0] SYNC = 16'h817E;
    localparam logic [15:0] NOOP = 16'h6969;
    localparam int LOCK_N  = 4;
    localparam int NOSYNC_N = 64;
    localparam logic [7:0] SYM [32] = '{8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
                                        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
                                        8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
                                        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};

    logic        CMD_CLK = 1'b0;
    logic        RESETB = 1'b0;
    logic        ENABLE = 1'b0;
    logic        CMD_SERIAL = 1'b0;
    logic        LOCKED, FRAME_VALID, FRAME_DATA_OK, LOCK_LOST;
    logic [15:0] FRAME_RAW, SYNC_CNT, FRAME_CNT;
    logic [9:0]  FRAME_DATA;

    tjmono2_cmd_rx dut (
        .CMD_CLK(CMD_CLK), .RESETB(RESETB), .ENABLE(ENABLE), .CMD_SERIAL(CMD_SERIAL),
        .LOCKED(LOCKED), .FRAME_VALID(FRAME_VALID), .FRAME_RAW(FRAME_RAW),
        .FRAME_DATA(FRAME_DATA), .FRAME_DATA_OK(FRAME_DATA_OK), .SYNC_CNT(SYNC_CNT),
        .FRAME_CNT(FRAME_CNT), .LOCK_LOST(LOCK_LOST)
    );

    always #3 CMD_CLK = ~CMD_CLK;

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;
    int lost_seen = 0;

    // reference model state: mode 0=searching, 1=aligning, 2=locked
    int          t = 0, anchor = 0, mode = 0, run = 0, nosync = 0;
    logic [15:0] win = '0;
    logic        m_locked = 0, m_fv = 0, m_ok = 0, m_lost = 0;
    logic [15:0] m_raw = '0, m_sync_cnt = '0, m_frame_cnt = '0;
    logic [9:0]  m_data = '0;

    function automatic logic [5:0] lookup(input logic [7:0] b);
        for (int i = 0; i < 32; i++)
            if (SYM[i] == b) return {1'b1, 5'(i)};
        return 6'd0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_step(input logic b);
        logic [5:0] h, l;
        logic bnd;
        t++;
        if (!RESETB) begin
            win = '0; mode = 0; run = 0; nosync = 0;
            m_locked = 0; m_fv = 0; m_ok = 0; m_lost = 0;
            m_raw = '0; m_data = '0; m_sync_cnt = '0; m_frame_cnt = '0;
            return;
        end
        win = {win[14:0], b};
        m_fv = 0; m_lost = 0;
        bnd = ((t - anchor) % 16) == 0;
        if (!ENABLE) begin
            if (mode == 2) m_lost = 1;
            mode = 0; run = 0;
        end else if (mode == 0) begin
            if (win == SYNC) begin
                anchor = t; run = 1; nosync = 0;
                mode = (run >= LOCK_N) ? 2 : 1;
            end
        end else if (mode == 1) begin
            if (bnd) begin
                if (win == SYNC) begin
                    run++;
                    if (run == LOCK_N) begin mode = 2; nosync = 0; end
                end else begin
                    mode = 0; run = 0;
                end
            end
        end else if (bnd) begin
            if (win == SYNC) begin
                if (m_sync_cnt != 16'hFFFF) m_sync_cnt++;
                nosync = 0;
            end else begin
                if (win != NOOP) begin
                    h = lookup(win[15:8]); l = lookup(win[7:0]);
                    m_fv = 1; m_raw = win; m_data = {h[4:0], l[4:0]}; m_ok = h[5] & l[5];
                    m_frame_cnt++;
                end
                nosync++;
                if (nosync == NOSYNC_N) begin mode = 0; run = 0; m_lost = 1; end
            end
        end
        m_locked = (mode == 2);
    endtask

    task automatic send_bit(input logic b);
        CMD_SERIAL = b;
        @(posedge CMD_CLK);
        #1;
        model_step(b);
        if (FRAME_VALID === 1'b1) fv_seen++;
        if (LOCK_LOST === 1'b1) lost_seen++;
        chk("locked", 16'(LOCKED), 16'(m_locked));
        chk("frame_valid", 16'(FRAME_VALID), 16'(m_fv));
        chk("lock_lost", 16'(LOCK_LOST), 16'(m_lost));
        chk("frame_raw", FRAME_RAW, m_raw);
        chk("frame_data", 16'(FRAME_DATA), 16'(m_data));
        chk("frame_data_ok", 16'(FRAME_DATA_OK), 16'(m_ok));
        chk("sync_cnt", SYNC_CNT, m_sync_cnt);
        chk("frame_cnt", FRAME_CNT, m_frame_cnt);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_syncs(input int n);
        for (int i = 0; i < n; i++) send_word(SYNC);
    endtask

    initial begin
        int fv0, lost0;
        logic [15:0] w;

        // reset state
        RESETB = 0; ENABLE = 0;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("rst_locked", 16'(LOCKED), 16'd0);
        chk("rst_frame_cnt", FRAME_CNT, 16'd0);
        RESETB = 1;
        send_bit(1'b0);

        // first lock and first frame
        ENABLE = 1;
        send_syncs(3);
        chk("no_lock_after_3", 16'(LOCKED), 16'd0);
        send_word(SYNC);
        chk("lock_after_4", 16'(LOCKED), 16'd1);
        send_word(16'h6A6C);
        chk("f1_valid", 16'(FRAME_VALID), 16'd1);
        chk("f1_raw", FRAME_RAW, 16'h6A6C);
        chk("f1_data", 16'(FRAME_DATA), 16'h001);
        chk("f1_ok", 16'(FRAME_DATA_OK), 16'd1);
        chk("f1_cnt", FRAME_CNT, 16'd1);
        chk("f1_sync_cnt", SYNC_CNT, 16'd0);
        send_bit(1'b0);
        chk("f1_strobe_one_cycle", 16'(FRAME_VALID), 16'd0);

        // disable drops lock, then realign at a 3-bit offset
        lost0 = lost_seen;
        ENABLE = 0;
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        chk("disable_lost_once", 16'(lost_seen - lost0), 16'd1);
        ENABLE = 1;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)));
        send_syncs(4);
        send_word(16'hD4D2);
        chk("f2_data", 16'(FRAME_DATA), 16'h3FE);
        chk("f2_ok", 16'(FRAME_DATA_OK), 16'd1);
        send_word(16'h8E71);
        chk("f3_valid", 16'(FRAME_VALID), 16'd1);

        // invalid symbol
        send_word(16'h2B6A);
        chk("bad_ok", 16'(FRAME_DATA_OK), 16'd0);
        chk("bad_data", 16'(FRAME_DATA), 16'h000);

        // 64 NOOPs drop lock once, no strobes
        send_word(SYNC);
        fv0 = fv_seen; lost0 = lost_seen;
        for (int i = 0; i < 63; i++) send_word(NOOP);
        chk("noop63_locked", 16'(LOCKED), 16'd1);
        send_word(NOOP);
        chk("noop64_unlocked", 16'(LOCKED), 16'd0);
        chk("noop_lost_once", 16'(lost_seen - lost0), 16'd1);
        chk("noop_no_frames", 16'(fv_seen - fv0), 16'd0);

        // interrupted sync run restarts the count
        send_syncs(2);
        send_word(16'h0000);
        chk("broken_run_unlocked", 16'(LOCKED), 16'd0);
        send_syncs(3);
        chk("relock_3", 16'(LOCKED), 16'd0);
        send_word(SYNC);
        chk("relock_4", 16'(LOCKED), 16'd1);

        // random frames while locked, some syncs mixed in
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(7))
                0: w = 16'($urandom);
                1: w = SYNC;
                2: w = NOOP;
                default: w = {SYM[$urandom_range(31)], SYM[$urandom_range(31)]};
            endcase
            send_word(w);
        end

        // random noise from the unlocked state
        ENABLE = 0;
        send_bit(1'b0);
        ENABLE = 1;
        for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(1)));

        // clean relock, then reset mid-frame
        ENABLE = 0;
        for (int i = 0; i < 16; i++) send_bit(1'b0);
        ENABLE = 1;
        send_syncs(4);
        send_word(16'hA5C3);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(1)));
        RESETB = 0;
        send_bit(1'b1);
        RESETB = 1;
        chk("midrst_locked", 16'(LOCKED), 16'd0);
        chk("midrst_frame_cnt", FRAME_CNT, 16'd0);
        chk("midrst_sync_cnt", SYNC_CNT, 16'd0);
        chk("midrst_raw", FRAME_RAW, 16'd0);
        send_syncs(3);
        chk("postrst_3", 16'(LOCKED), 16'd0);
        send_word(SYNC);
        chk("postrst_4", 16'(LOCKED), 16'd1);
        send_word(16'hCCD1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
